eth_phy_10g_tx_gearbox: RTL and testbench

//  66b->64b transmit gearbox between the 10GBASE-R TX interface (scrambler/PRBS31 output)
//  and a 64-bit SERDES with no internal gearbox. Packs each 2-bit sync header plus 64-bit

---
 rtl/eth_phy_10g_tx_gearbox.sv | 101 ++++++++++
 tb/tb_eth_phy_10g_tx_gearbox.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/eth_phy_10g_tx_gearbox.sv
// eth_phy_10g_tx_gearbox
// 66b -> 64b transmit gearbox for a 10GBASE-R PCS feeding a 64-bit SERDES
// that has no gearbox of its own. Each 2-bit sync header and its 64-bit
// payload are packed into a continuous 64-bit word stream. Every 33-cycle
// sequence accepts 32 blocks, then pauses for one cycle while the residue
// buffer, which is full at that point, is drained.
//
// Ports
//   clk             in   1   clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   serdes_tx_data  in   64  scrambled block payload, bit 0 sent first
//   serdes_tx_hdr   in   2   sync header, bit 0 sent first, precedes payload
//   tx_in_ready     out  1   1: input block consumed this cycle, 0: pause
//   gbx_tx_data     out  64  registered word to SERDES, bit 0 sent first
//                            (bit order mirrored when BIT_REVERSE=1)
//   gbx_tx_seq      out  6   registered sequence count 0..32
module eth_phy_10g_tx_gearbox #(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter bit BIT_REVERSE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] serdes_tx_data,
    input  logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
    output logic                  tx_in_ready,
    output logic [DATA_WIDTH-1:0] gbx_tx_data,
    output logic [5:0]            gbx_tx_seq
);

    localparam int          BLK_W     = DATA_WIDTH + HDR_WIDTH;
    localparam int          EXT_W     = 2 * DATA_WIDTH;
    localparam logic [5:0]  SEQ_PAUSE = 6'd32;

    // The packing arithmetic below only holds for the 64b/66b geometry.
    generate
        if (DATA_WIDTH != 64 || HDR_WIDTH != 2) begin : g_bad_geometry
            $error("eth_phy_10g_tx_gearbox supports only DATA_WIDTH=64, HDR_WIDTH=2");
        end
    endgenerate

    logic [5:0]            seq_q, seq_d;
    logic [6:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] word;
    logic [BLK_W-1:0]      blk;
    logic [EXT_W-1:0]      ext;
    logic                  pause;

    assign pause       = (seq_q == SEQ_PAUSE);
    assign tx_in_ready = ~pause;
    assign gbx_tx_data = data_q;
    assign gbx_tx_seq  = seq_q;

    always_comb begin
        blk   = {serdes_tx_data, serdes_tx_hdr};
        // cnt never exceeds 62 on an accept cycle, so blk << cnt tops out at
        // bit 127 and a 128-bit window loses nothing.
        ext   = {{(EXT_W-DATA_WIDTH){1'b0}}, rem_q}
              | ({{(EXT_W-BLK_W){1'b0}}, blk} << cnt_q);
        seq_d = pause ? 6'd0 : seq_q + 6'd1;
        if (pause) begin
            word  = rem_q;
            rem_d = '0;
            cnt_d = 7'd0;
        end else begin
            word  = ext[DATA_WIDTH-1:0];
            rem_d = ext[EXT_W-1:DATA_WIDTH];
            cnt_d = cnt_q + 7'd2;
        end
    end

    always_comb begin
        data_d = word;
        if (BIT_REVERSE) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                data_d[i] = word[DATA_WIDTH-1-i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q  <= '0;
            cnt_q  <= '0;
            rem_q  <= '0;
            data_q <= '0;
        end else begin
            seq_q  <= seq_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            data_q <= data_d;
        end
    end

    // Residue bit count must track the sequence: two extra bits per block.
    a_cnt_tracks_seq: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q == {seq_q, 1'b0});

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
module tb_eth_phy_10g_tx_gearbox;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] tx_data = '0;
    logic [1:0]  tx_hdr = '0;
    logic        rdy, rdy_r;
    logic [63:0] gbx, gbx_r;
    logic [5:0]  seq, seq_r;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eth_phy_10g_tx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2), .BIT_REVERSE(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .serdes_tx_data(tx_data), .serdes_tx_hdr(tx_hdr),
        .tx_in_ready(rdy), .gbx_tx_data(gbx), .gbx_tx_seq(seq));

    eth_phy_10g_tx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2), .BIT_REVERSE(1'b1)) u_dut_rev (
        .clk(clk), .rst_n(rst_n),
        .serdes_tx_data(tx_data), .serdes_tx_hdr(tx_hdr),
        .tx_in_ready(rdy_r), .gbx_tx_data(gbx_r), .gbx_tx_seq(seq_r));

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    // Reference model: an ideal serial bit queue. Every accepted block is
    // appended LSB first (header, then payload); every cycle one 64-bit word
    // leaves from the front. Cycles since reset, modulo 33, decide the pause.
    bit          bitq[$];
    logic [65:0] sent[$];
    int          m_seq = 0;
    logic [63:0] exp_word = '0;
    bit          started = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitq.delete();
            sent.delete();
            m_seq    = 0;
            exp_word = '0;
            started  = 1'b0;
        end else begin
            if (m_seq != 32) begin
                for (int i = 0; i < 2; i++)  bitq.push_back(tx_hdr[i]);
                for (int i = 0; i < 64; i++) bitq.push_back(tx_data[i]);
                sent.push_back({tx_data, tx_hdr});
            end
            for (int i = 0; i < 64; i++) begin
                exp_word[i] = (bitq.size() > 0) ? bitq.pop_front() : 1'bx;
            end
            m_seq   = (m_seq + 1) % 33;
            started = 1'b1;
        end
    end

    // Per-cycle compare plus block recovery from the serial output stream.
    bit          outq[$];
    int          recovered = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_data", {2'b0, gbx}, 66'd0);
            chk("rst_seq", {60'd0, seq}, 66'd0);
            chk("rst_ready", {65'd0, rdy}, 66'd1);
            outq.delete();
            recovered = 0;
        end else begin
            chk("ready", {65'd0, rdy}, {65'd0, (m_seq != 32)});
            chk("seq", {60'd0, seq}, 66'(m_seq));
            chk("word", {2'b0, gbx}, {2'b0, exp_word});
            chk("word_rev", {2'b0, gbx_r}, {2'b0, rev64(exp_word)});
            chk("seq_rev", {60'd0, seq_r}, 66'(m_seq));
            if (started) begin
                for (int i = 0; i < 64; i++) outq.push_back(gbx[i]);
                while (outq.size() >= 66) begin
                    logic [65:0] b;
                    for (int i = 0; i < 66; i++) b[i] = outq.pop_front();
                    if (sent.size() == 0) begin
                        chk("recover_underrun", 66'd1, 66'd0);
                    end else begin
                        chk("recover_block", b, sent.pop_front());
                    end
                    recovered++;
                end
            end
        end
    end

    task automatic enter_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", {2'b0, gbx}, 66'd0);
        chk("async_rst_seq", {60'd0, seq}, 66'd0);
        chk("async_rst_ready", {65'd0, rdy}, 66'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        // Constant hdr=01, data=0; junk payload offered during pauses.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tx_hdr = 2'b01; tx_data = '0;
        rst_n = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            int p;
            @(posedge clk); #1;
            p = (c - 1) % 33;
            if (p < 32) begin
                chk("const01_word", {2'b0, gbx}, {2'b0, 64'h1 << (2 * p)});
                chk("const01_rev", {2'b0, gbx_r}, {2'b0, 64'h8000_0000_0000_0000 >> (2 * p)});
            end else begin
                chk("const01_pause_word", {2'b0, gbx}, 66'd0);
            end
            if (c == 32 || c == 65 || c == 98) chk("pause_ready_low", {65'd0, rdy}, 66'd0);
            if (c == 31 || c == 33 || c == 64 || c == 99) chk("ready_high", {65'd0, rdy}, 66'd1);
            if (c % 33 == 32) begin
                tx_hdr = 2'b11; tx_data = 64'hDEAD_BEEF_DEAD_BEEF;
            end else begin
                tx_hdr = 2'b01; tx_data = '0;
            end
        end

        // Mid-stream reset, then hdr=10 with all-ones payload.
        enter_reset();
        tx_hdr = 2'b10; tx_data = 64'hFFFF_FFFF_FFFF_FFFF;
        rst_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                chk("ones_word0", {2'b0, gbx}, {2'b0, 64'hFFFF_FFFF_FFFF_FFFE});
                chk("ones_hdr_pos", {64'd0, gbx[1:0]}, 66'd2);
            end
            if (c == 33) chk("ones_pause_word", {2'b0, gbx}, {2'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        end

        // Random blocks for 10 full sequences after another mid-stream reset.
        enter_reset();
        tx_hdr = 2'($urandom); tx_data = {$urandom, $urandom};
        rst_n = 1'b1;
        for (int c = 1; c <= 330; c++) begin
            @(posedge clk); #1;
            tx_hdr = 2'($urandom); tx_data = {$urandom, $urandom};
        end
        @(negedge clk); #1;
        chk("recovered_blocks", 66'(recovered), 66'd320);

        repeat (5) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
